program_loader: RTL and testbench

Byte-stream program loader that fills the instruction and data BRAMs of the rv32i single-cycle core before execution, then releases the core. It sits directly upstream of the fetch stage: it drives the instruction BRAM write port, the data BRAM init write port, the `pc_stall` line and `d_bram_init_done`. It accepts framed, checksummed bytes from a UART RX or a testbench.

---
 rtl/program_loader.sv | 207 ++++++++++++++++++++
 tb/tb_program_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader : framed, checksummed byte-stream loader for the rv32i
//                  instruction/data BRAMs; releases the core on 'G'.
// Revision 1.0
// ============================================================================

module program_loader #(
    parameter int  ADDR_WIDTH = 12,
    parameter int  MAX_WORDS  = 1024,
    localparam int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_dat,
    output logic [3:0]            w_byte_enb,
    output logic                  i_w_enb,
    output logic                  d_w_enb,
    output logic                  pc_stall,
    output logic                  d_bram_init_done,
    output logic                  busy,
    output logic                  error
);

    localparam int         IDX_W = ADDR_WIDTH - 2;
    localparam logic [7:0] CMD_I = 8'h49;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_G = 8'h47;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_LO  = 3'd1,
        ST_CNT_HI  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_WRITE   = 3'd4,
        ST_CHECK   = 3'd5,
        ST_RUN     = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [7:0]              sum_q, sum_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [1:0]              bcnt_q, bcnt_d;
    logic                    tgt_q, tgt_d;          // 1 = data BRAM

    logic                    s_ready_q, s_ready_d;
    logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0]   w_dat_q, w_dat_d;
    logic                    i_we_q, i_we_d;
    logic                    d_we_q, d_we_d;
    logic                    pc_stall_q, pc_stall_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    error_q, error_d;

    logic                    byte_fire;
    logic [15:0]             cnt_new;
    logic                    last_word;

    assign byte_fire = s_valid && s_ready_q;
    assign cnt_new   = {s_data, cnt_q[7:0]};
    assign last_word = (16'(idx_q) + 16'd1) == cnt_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        word_d   = word_q;
        bcnt_d   = bcnt_q;
        tgt_d    = tgt_q;
        w_addr_d = w_addr_q;
        w_dat_d  = w_dat_q;
        i_we_d   = 1'b0;
        d_we_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_fire) begin
                    if (s_data == CMD_I || s_data == CMD_D) begin
                        state_d = ST_CNT_LO;
                        tgt_d   = (s_data == CMD_D);
                        idx_d   = '0;
                        sum_d   = '0;
                        bcnt_d  = '0;
                    end else if (s_data == CMD_G) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_CNT_LO: begin
                if (byte_fire) begin
                    cnt_d[7:0] = s_data;
                    sum_d      = sum_q + s_data;
                    state_d    = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (byte_fire) begin
                    cnt_d = cnt_new;
                    sum_d = sum_q + s_data;
                    if (cnt_new == 16'd0 || int'(cnt_new) > MAX_WORDS)
                        state_d = ST_ERROR;
                    else
                        state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (byte_fire) begin
                    // Shift in from the top so the first byte ends in [7:0].
                    word_d = {s_data, word_q[DATA_WIDTH-1:8]};
                    sum_d  = sum_q + s_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d  = ST_WRITE;
                        w_addr_d = {idx_q, 2'b00};
                        w_dat_d  = word_d;
                        i_we_d   = !tgt_q;
                        d_we_d   = tgt_q;
                    end
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 1'b1;
                state_d = last_word ? ST_CHECK : ST_PAYLOAD;
            end
            ST_CHECK: begin
                if (byte_fire)
                    state_d = (s_data == sum_q) ? ST_IDLE : ST_ERROR;
            end
            ST_RUN:   state_d = ST_RUN;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        s_ready_d  = (state_d == ST_IDLE)    || (state_d == ST_CNT_LO) ||
                     (state_d == ST_CNT_HI)  || (state_d == ST_PAYLOAD) ||
                     (state_d == ST_CHECK);
        busy_d     = !((state_d == ST_IDLE) || (state_d == ST_RUN) ||
                       (state_d == ST_ERROR));
        error_d    = (state_d == ST_ERROR);
        // Core release lags RUN entry by one cycle.
        pc_stall_d = (state_q != ST_RUN);
        done_d     = (state_q == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            word_q     <= '0;
            bcnt_q     <= '0;
            tgt_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            w_addr_q   <= '0;
            w_dat_q    <= '0;
            i_we_q     <= 1'b0;
            d_we_q     <= 1'b0;
            pc_stall_q <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            tgt_q      <= tgt_d;
            s_ready_q  <= s_ready_d;
            w_addr_q   <= w_addr_d;
            w_dat_q    <= w_dat_d;
            i_we_q     <= i_we_d;
            d_we_q     <= d_we_d;
            pc_stall_q <= pc_stall_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign s_ready          = s_ready_q;
    assign w_addr           = w_addr_q;
    assign w_dat            = w_dat_q;
    assign w_byte_enb       = (i_we_q || d_we_q) ? 4'b1111 : 4'b0000;
    assign i_w_enb          = i_we_q;
    assign d_w_enb          = d_we_q;
    assign pc_stall         = pc_stall_q;
    assign d_bram_init_done = done_q;
    assign busy             = busy_q;
    assign error            = error_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// tb_program_loader : randomized self-checking bench for program_loader
// Revision 1.0
// ============================================================================

module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic [11:0] w_addr;
    logic [31:0] w_dat;
    logic [3:0]  w_byte_enb;
    logic        i_w_enb, d_w_enb, pc_stall, d_bram_init_done, busy, error;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        is_d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] frame_words[$];

    program_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .w_addr(w_addr), .w_dat(w_dat),
        .w_byte_enb(w_byte_enb), .i_w_enb(i_w_enb), .d_w_enb(d_w_enb),
        .pc_stall(pc_stall), .d_bram_init_done(d_bram_init_done),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write-port scoreboard: every pulse must match the next expected write.
    always @(negedge clk) begin
        if (mon_en) begin
            if (i_w_enb || d_w_enb) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("w_addr", w_addr, mon_e.addr);
                    check("w_dat", w_dat, mon_e.data);
                    check("w_enb_sel", {i_w_enb, d_w_enb}, mon_e.is_d ? 2'b01 : 2'b10);
                    check("w_be_on", w_byte_enb, 4'hF);
                end
            end else begin
                check("w_be_off", w_byte_enb, 4'h0);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_s_ready", s_ready, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_dat", w_dat, 0);
        check("rst_w_be", w_byte_enb, 0);
        check("rst_i_we", i_w_enb, 0);
        check("rst_d_we", d_w_enb, 0);
        check("rst_pc_stall", pc_stall, 1);
        check("rst_done", d_bram_init_done, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", s_ready, 1);
    endtask

    // Present one byte after a random gap; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int waited;
        int gap;
        waited = 0;
        gap = int'($urandom_range(0, max_gap));
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = b;
        while (1) begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Builds a load frame from frame_words and records the writes it implies.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] sum_delta, input int max_gap);
        logic [7:0]  pay[$];
        logic [15:0] cnt;
        logic [7:0]  sum;
        wr_t         e;
        cnt = 16'(frame_words.size());
        for (int i = 0; i < frame_words.size(); i++) begin
            for (int k = 0; k < 4; k++) pay.push_back(frame_words[i][8*k +: 8]);
            e.addr = 12'(i * 4);
            e.data = frame_words[i];
            e.is_d = (cmd == 8'h44);
            exp_q.push_back(e);
        end
        sum = cnt[7:0] + cnt[15:8];
        foreach (pay[k]) sum = sum + pay[k];
        send_byte(cmd, max_gap);
        check("busy_after_cmd", busy, 1);
        send_byte(cnt[7:0], max_gap);
        send_byte(cnt[15:8], max_gap);
        for (int k = 0; k < pay.size(); k++) begin
            send_byte(pay[k], max_gap);
            if (k % 4 == 3) begin
                check("wr_latency", i_w_enb | d_w_enb, 1);
                check("wr_ready_low", s_ready, 0);
            end
        end
        send_byte(sum + sum_delta, max_gap);
    endtask

    task automatic expect_idle_ok(input string tag);
        check({tag, "_error"}, error, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, s_ready, 1);
    endtask

    task automatic expect_error(input string tag);
        check({tag, "_error"}, error, 1);
        check({tag, "_ready"}, s_ready, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic probe_blocked_go();
        s_valid = 1'b1;
        s_data  = 8'h47;
        repeat (5) begin
            @(negedge clk);
            check("blocked_ready", s_ready, 0);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("blocked_pc_stall", pc_stall, 1);
        check("blocked_done", d_bram_init_done, 0);
    endtask

    task automatic rand_words(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) frame_words.push_back($urandom);
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;

        // Instruction frame from the known program
        frame_words = '{32'h00500293, 32'h00200313, 32'h40628A33, 32'h01402623, 32'h00000013};
        send_frame(8'h49, 8'h00, 1);
        expect_idle_ok("i_frame");

        // Data frame then go
        frame_words = '{32'h00000001, 32'h00000002};
        send_frame(8'h44, 8'h00, 0);
        expect_idle_ok("d_frame");
        send_byte(8'h47, 0);
        check("go_ready", s_ready, 0);
        check("go_stall_lag", pc_stall, 1);
        check("go_done_lag", d_bram_init_done, 0);
        @(posedge clk); #1;
        check("go_stall", pc_stall, 0);
        check("go_done", d_bram_init_done, 1);
        repeat (3) @(posedge clk);
        #1 check("run_ready", s_ready, 0);
        check("run_busy", busy, 0);

        // Bad checksum
        do_reset();
        rand_words(1);
        send_frame(8'h44, 8'h01, 0);
        expect_error("bad_sum");
        probe_blocked_go();

        // Count 0 and count above the limit
        do_reset();
        send_byte(8'h49, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        expect_error("cnt_zero");
        do_reset();
        send_byte(8'h44, 0); send_byte(8'h01, 0); send_byte(8'h04, 0);
        expect_error("cnt_over");

        // Unknown command
        do_reset();
        send_byte(8'h55, 0);
        expect_error("bad_cmd");
        check("bad_cmd_stall", pc_stall, 1);

        // Reset in the middle of a payload word, coinciding with a valid byte
        do_reset();
        send_byte(8'h49, 0); send_byte(8'h03, 0); send_byte(8'h00, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0);
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 8'hAA;
        @(posedge clk); #1;
        check_reset_vals();
        rst = 1'b0;
        s_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", s_ready, 1);
        rand_words(3);
        send_frame(8'h49, 8'h00, 3);
        expect_idle_ok("post_rst_frame");

        // Randomized back-to-back frames with random gaps
        for (int f = 0; f < 6; f++) begin
            rand_words(int'($urandom_range(1, 6)));
            send_frame(($urandom_range(0, 1) == 1) ? 8'h44 : 8'h49, 8'h00, 3);
            expect_idle_ok("rand_frame");
        end

        // Largest legal count
        rand_words(1024);
        send_frame(8'h44, 8'h00, 0);
        expect_idle_ok("max_frame");

        repeat (3) @(posedge clk);
        #1 check("pending_writes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
